// File: rtl/reg_writeback_pkg.sv
// reg_writeback shared types.
// Register-file widths and the writeback entry.
package reg_writeback_pkg;

  localparam int REG_AW = 5;
  localparam int REG_DW = 32;

  localparam logic [REG_AW-1:0] REG_ZERO = '0;

  typedef struct packed {
    logic [REG_AW-1:0] dest;
    logic [REG_DW-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/reg_writeback_fifo.sv
// wb_fifo: circular buffer for ALU results.
// Exports per-slot valid and dest for the pending mask.
module wb_fifo
  import reg_writeback_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  wb_entry_t              push_ent,
  input  logic                   pop,
  output wb_entry_t              head,
  output logic [PW:0]            count,
  output logic                   full,
  output logic                   empty,
  output logic [DEPTH-1:0]       vld,
  output logic [DEPTH-1:0][REG_AW-1:0] dests
);

  wb_entry_t        mem_q [DEPTH];
  wb_entry_t        mem_d [DEPTH];
  logic [PW-1:0]    wr_q, wr_d;
  logic [PW-1:0]    rd_q, rd_d;
  logic [PW:0]      cnt_q, cnt_d;
  logic [DEPTH-1:0] vld_q, vld_d;

  // Next-state: pop frees the head slot, push fills the tail.
  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    vld_d = vld_q;
    if (pop) begin
      vld_d[rd_q] = 1'b0;
      rd_d        = rd_q + 1'b1;
    end
    if (push) begin
      mem_d[wr_q] = push_ent;
      vld_d[wr_q] = 1'b1;
      wr_d        = wr_q + 1'b1;
    end
    cnt_d = cnt_q
          + {{PW{1'b0}}, push}
          - {{PW{1'b0}}, pop};
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++)
        mem_q[i] <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      vld_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
      vld_q <= vld_d;
    end
  end

  // Slot destinations for the pending decode.
  always_comb begin
    for (int i = 0; i < DEPTH; i++)
      dests[i] = mem_q[i].dest;
  end

  assign head  = mem_q[rd_q];
  assign count = cnt_q;
  assign full  = (cnt_q == (PW+1)'(DEPTH));
  assign empty = (cnt_q == '0);
  assign vld   = vld_q;

endmodule

// File: rtl/reg_writeback.sv
// reg_writeback: merges loads and ALU results
// onto the single register-file write port.
module reg_writeback
  import reg_writeback_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int DW    = REG_DW,
  parameter int AW    = REG_AW
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ld_valid,
  input  logic [AW-1:0]   ld_dest,
  input  logic [DW-1:0]   ld_data,
  input  logic            alu_valid,
  input  logic [AW-1:0]   alu_dest,
  input  logic [DW-1:0]   alu_data,
  output logic            alu_ready,
  output logic            ctl_regWrite,
  output logic [AW-1:0]   instrToWrite,
  output logic [DW-1:0]   reg_writeData,
  output logic [2**AW-1:0] pend_mask,
  output logic            busy
);

  localparam int PW = $clog2(DEPTH);

  wb_entry_t              head;
  wb_entry_t              push_ent;
  logic [PW:0]            f_cnt;
  logic                   f_full;
  logic                   f_empty;
  logic [DEPTH-1:0]       f_vld;
  logic [DEPTH-1:0][AW-1:0] f_dests;

  logic ld_sel;
  logic alu_acc;
  logic alu_nz;
  logic f_pop;
  logic byp;
  logic f_push;

  logic          wen_q, wen_d;
  logic [AW-1:0] waddr_q, waddr_d;
  logic [DW-1:0] wdata_q, wdata_d;

  assign alu_ready = rst_n && !f_full;
  assign alu_acc   = alu_valid && alu_ready;
  assign alu_nz    = alu_acc
                  && (alu_dest != REG_ZERO);
  assign ld_sel    = ld_valid
                  && (ld_dest != REG_ZERO);
  assign f_pop     = !ld_sel && !f_empty;
  assign byp       = !ld_sel && f_empty
                  && alu_nz;
  assign f_push    = alu_nz && !byp;

  assign push_ent.dest = alu_dest;
  assign push_ent.data = alu_data;

  wb_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (f_push),
    .push_ent (push_ent),
    .pop      (f_pop),
    .head     (head),
    .count    (f_cnt),
    .full     (f_full),
    .empty    (f_empty),
    .vld      (f_vld),
    .dests    (f_dests)
  );

  // Pick one write: load, then queue head, then bypass.
  always_comb begin
    wen_d   = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    unique case (1'b1)
      ld_sel: begin
        wen_d   = 1'b1;
        waddr_d = ld_dest;
        wdata_d = ld_data;
      end
      f_pop: begin
        wen_d   = 1'b1;
        waddr_d = head.dest;
        wdata_d = head.data;
      end
      byp: begin
        wen_d   = 1'b1;
        waddr_d = alu_dest;
        wdata_d = alu_data;
      end
      default: ;
    endcase
  end

  // Registered write port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wen_q   <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      wen_q   <= wen_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
    end
  end

  // Registers still waiting in the queue.
  always_comb begin
    pend_mask = '0;
    for (int i = 0; i < DEPTH; i++)
      if (f_vld[i])
        pend_mask[f_dests[i]] = 1'b1;
  end

  assign ctl_regWrite  = wen_q;
  assign instrToWrite  = waddr_q;
  assign reg_writeData = wdata_q;
  assign busy          = !f_empty;

  logic unused_cnt;
  assign unused_cnt = ^f_cnt;

endmodule

// File: tb/tb_reg_writeback.sv
// tb_reg_writeback: table vectors, hand
// sequences and a queue-model random run.
module tb_reg_writeback;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ld_valid;
  logic [4:0]  ld_dest;
  logic [31:0] ld_data;
  logic        alu_valid;
  logic [4:0]  alu_dest;
  logic [31:0] alu_data;
  logic        alu_ready;
  logic        ctl_regWrite;
  logic [4:0]  instrToWrite;
  logic [31:0] reg_writeData;
  logic [31:0] pend_mask;
  logic        busy;

  int checks = 0;
  int fails  = 0;

  typedef struct packed {
    logic [4:0]  dest;
    logic [31:0] data;
  } ent_t;

  ent_t       mq[$];
  logic [4:0] wlog[$];

  typedef struct {
    logic        lv;
    logic [4:0]  ld;
    logic [31:0] ldd;
    logic        av;
    logic [4:0]  ad;
    logic [31:0] add;
    logic        en;
    logic [4:0]  a;
    logic [31:0] d;
    logic [31:0] pend;
    logic        bsy;
  } vec_t;

  vec_t tbl[9];

  always #5 clk = ~clk;

  reg_writeback #(.DEPTH(DEPTH)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .ld_valid      (ld_valid),
    .ld_dest       (ld_dest),
    .ld_data       (ld_data),
    .alu_valid     (alu_valid),
    .alu_dest      (alu_dest),
    .alu_data      (alu_data),
    .alu_ready     (alu_ready),
    .ctl_regWrite  (ctl_regWrite),
    .instrToWrite  (instrToWrite),
    .reg_writeData (reg_writeData),
    .pend_mask     (pend_mask),
    .busy          (busy)
  );

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h want %0h",
               nm, act, exp);
    end
  endtask

  // One cycle against the queue model.
  task automatic cycle(input logic lv,
                       input logic [4:0] ld,
                       input logic [31:0] ldd,
                       input logic av,
                       input logic [4:0] ad,
                       input logic [31:0] add,
                       output logic acc);
    logic        e_en;
    logic [4:0]  e_a;
    logic [31:0] e_d;
    logic        used;
    logic [31:0] e_pm;
    ent_t        h;
    ld_valid  = lv;
    ld_dest   = ld;
    ld_data   = ldd;
    alu_valid = av;
    alu_dest  = ad;
    alu_data  = add;
    acc = av && (mq.size() < DEPTH);
    chk("ready", 64'(alu_ready),
        64'(mq.size() < DEPTH));
    e_en = 0; e_a = 0; e_d = 0; used = 0;
    if (lv && ld != 0) begin
      e_en = 1; e_a = ld; e_d = ldd;
    end else if (mq.size() > 0) begin
      h = mq.pop_front();
      e_en = 1; e_a = h.dest; e_d = h.data;
    end else if (acc && ad != 0) begin
      e_en = 1; e_a = ad; e_d = add;
      used = 1;
    end
    if (acc && ad != 0 && !used)
      mq.push_back('{dest: ad, data: add});
    e_pm = 0;
    foreach (mq[i]) e_pm[mq[i].dest] = 1'b1;
    @(posedge clk);
    #1;
    if (ctl_regWrite) wlog.push_back(instrToWrite);
    chk("wen", 64'(ctl_regWrite), 64'(e_en));
    if (e_en) begin
      chk("waddr", 64'(instrToWrite), 64'(e_a));
      chk("wdata", 64'(reg_writeData), 64'(e_d));
    end
    chk("pend", 64'(pend_mask), 64'(e_pm));
    chk("busy", 64'(busy), 64'(mq.size() != 0));
  endtask

  initial begin
    logic acc;
    int   idx;
    int   bad;
    logic [4:0] seq[$];

    rst_n = 0; ld_valid = 0; ld_dest = 0;
    ld_data = 0; alu_valid = 0; alu_dest = 0;
    alu_data = 0;

    // Reset
    #3;
    chk("rst_wen", 64'(ctl_regWrite), 0);
    chk("rst_addr", 64'(instrToWrite), 0);
    chk("rst_data", 64'(reg_writeData), 0);
    chk("rst_pend", 64'(pend_mask), 0);
    chk("rst_ready", 64'(alu_ready), 0);
    chk("rst_busy", 64'(busy), 0);
    @(negedge clk);
    rst_n = 1;
    @(posedge clk);
    #1;
    chk("rel_ready", 64'(alu_ready), 1);

    // Table vectors from an empty queue
    tbl[0] = '{0, 0, 0, 1, 5, 32'hDEADBEEF,
               1, 5, 32'hDEADBEEF, 0, 0};
    tbl[1] = '{0, 0, 0, 0, 0, 0,
               0, 0, 0, 0, 0};
    tbl[2] = '{1, 3, 32'h11, 1, 7, 32'h22,
               1, 3, 32'h11, 32'h80, 1};
    tbl[3] = '{0, 0, 0, 0, 0, 0,
               1, 7, 32'h22, 0, 0};
    tbl[4] = '{0, 0, 0, 0, 0, 0,
               0, 0, 0, 0, 0};
    tbl[5] = '{0, 0, 0, 1, 0, 32'hFFFF,
               0, 0, 0, 0, 0};
    tbl[6] = '{1, 0, 32'h1234, 0, 0, 0,
               0, 0, 0, 0, 0};
    tbl[7] = '{1, 0, 32'h55, 1, 9, 32'h99,
               1, 9, 32'h99, 0, 0};
    tbl[8] = '{0, 0, 0, 0, 0, 0,
               0, 0, 0, 0, 0};
    for (int i = 0; i < 9; i++) begin
      ld_valid  = tbl[i].lv;
      ld_dest   = tbl[i].ld;
      ld_data   = tbl[i].ldd;
      alu_valid = tbl[i].av;
      alu_dest  = tbl[i].ad;
      alu_data  = tbl[i].add;
      chk("t_ready", 64'(alu_ready), 1);
      @(posedge clk);
      #1;
      chk("t_wen", 64'(ctl_regWrite),
          64'(tbl[i].en));
      if (tbl[i].en) begin
        chk("t_addr", 64'(instrToWrite),
            64'(tbl[i].a));
        chk("t_data", 64'(reg_writeData),
            64'(tbl[i].d));
      end
      chk("t_pend", 64'(pend_mask),
          64'(tbl[i].pend));
      chk("t_busy", 64'(busy),
          64'(tbl[i].bsy));
    end

    // Fill and drain
    wlog.delete();
    idx = 1;
    for (int i = 0; i < 6; i++) begin
      cycle(1, 5'(20 + i), 32'(100 + i),
            idx <= 6, 5'(idx), 32'(idx), acc);
      if (acc) idx++;
      if (i == 3)
        chk("fill_ready_low", 64'(alu_ready), 0);
    end
    for (int c = 0; c < 30; c++) begin
      cycle(0, 0, 0, idx <= 6, 5'(idx),
            32'(idx), acc);
      if (acc) idx++;
    end
    chk("fill_accepts", 64'(idx), 7);
    for (int i = 0; i < 6; i++)
      seq.push_back(5'(20 + i));
    for (int i = 1; i <= 6; i++)
      seq.push_back(5'(i));
    chk("fill_nwr", 64'(wlog.size()),
        64'(seq.size()));
    foreach (seq[i])
      if (i < wlog.size())
        chk("fill_order", 64'(wlog[i]),
            64'(seq[i]));

    // Reset while entries are queued
    wlog.delete();
    for (int i = 0; i < 3; i++)
      cycle(1, 5'(21 + i), 32'(i), 1,
            5'(8 + i), 32'(200 + i), acc);
    chk("mid_pend", 64'(pend_mask), 64'h700);
    #2;
    rst_n = 0;
    ld_valid = 0;
    alu_valid = 0;
    #1;
    chk("mid_wen", 64'(ctl_regWrite), 0);
    chk("mid_addr", 64'(instrToWrite), 0);
    chk("mid_data", 64'(reg_writeData), 0);
    chk("mid_pend0", 64'(pend_mask), 0);
    chk("mid_ready", 64'(alu_ready), 0);
    chk("mid_busy", 64'(busy), 0);
    mq.delete();
    @(negedge clk);
    rst_n = 1;
    @(posedge clk);
    #1;
    for (int c = 0; c < 10; c++)
      cycle(0, 0, 0, 0, 0, 0, acc);
    bad = 0;
    foreach (wlog[i])
      if (wlog[i] >= 8 && wlog[i] <= 10)
        bad++;
    chk("mid_no_stale", 64'(bad), 0);

    // Random traffic against the model
    for (int c = 0; c < 400; c++)
      cycle($urandom % 3 == 0,
            5'($urandom % 8), $urandom,
            $urandom % 4 != 0,
            5'($urandom % 8), $urandom, acc);
    for (int c = 0; c < 8; c++)
      cycle(0, 0, 0, 0, 0, 0, acc);

    $display(
      "End of test - %0d assertions evaluated, %0d failures",
      checks, fails);
    $finish;
  end

endmodule

// File: doc/reg_writeback.md
Name: reg_writeback

Overview:
- Write-port driver for the register file.
- Merges two writeback sources into the file's single write port:
  - load returns from data memory, which must be accepted every cycle;
  - ALU results, which use a valid/ready handshake.
- A small FIFO holds ALU results whenever a load occupies the port.
- Exports a pending-write mask so decode can stall on registers whose data is still queued.

Parameters:
- DEPTH, 4, ALU holding FIFO entries (power of two, >=2).
- DW, 32, data width.
- AW, 5, register address width.

Ports:
- clk  input  1  clock; all state updates on posedge. The register file samples the write port on negedge.
- rst_n  input  1  asynchronous active-low reset.
- ld_valid  input  1  load result present this cycle; always accepted, no ready.
- ld_dest  input  AW  load destination register.
- ld_data  input  DW  load data.
- alu_valid  input  1  ALU result offered.
- alu_dest  input  AW  ALU destination register.
- alu_data  input  DW  ALU data.
- alu_ready  output  1  ALU result accepted when alu_valid && alu_ready at posedge.
- ctl_regWrite  output  1  register-file write enable (registered).
- instrToWrite  output  AW  register-file write address (registered).
- reg_writeData  output  DW  register-file write data (registered).
- pend_mask  output  2**AW  bit r = 1 while any queued FIFO entry targets register r.
- busy  output  1  FIFO non-empty.

Behaviour:
- Reset (rst_n low, asynchronous):
  - ctl_regWrite=0, instrToWrite=0, reg_writeData=0.
  - FIFO emptied, pend_mask=0, busy=0, alu_ready=0.
  - Any entries queued at reset are discarded and never written.
- alu_ready = rst_n && (count < DEPTH). It depends on count only; a same-cycle dequeue does not raise it.
- Each posedge selects at most one write, in priority order:
  1. ld_valid;
  2. FIFO head;
  3. accepted ALU result, bypassing the FIFO only when it is empty.
- Selected write appears on ctl_regWrite/instrToWrite/reg_writeData the cycle after the posedge (latency 1) and holds for exactly one cycle. ctl_regWrite=0 when nothing is selected.
- Any accepted ALU result not selected that cycle is enqueued at the FIFO tail:
  - ld_valid present: enqueue.
  - FIFO non-empty: enqueue.
- Simultaneous dequeue and enqueue in one cycle is legal; count is unchanged.
- FIFO order is strict FIFO. Pointers wrap modulo DEPTH. count is AW-independent, width log2(DEPTH)+1.
- Destination 0:
  - An accepted ALU result with alu_dest=0 is consumed and not enqueued.
  - ld_valid with ld_dest=0 is ignored.
  - Neither produces ctl_regWrite.
- pend_mask is combinational OR-decode over valid FIFO entries. The bit clears in the cycle the entry's write is driven on the port.
- Write-after-write ordering between the load and ALU sources is the issuer's responsibility (decode stalls on pend_mask). The block never reorders within the ALU stream.
- ld_valid while FIFO is full is still accepted; the FIFO simply does not drain that cycle.
- Outputs change only on posedge, so they are stable at the register file's negedge sample.

Decomposition:
- Shared package holds:
  - REG_AW=5, REG_DW=32;
  - REG_ZERO constant;
  - wb_entry_t struct {dest[AW], data[DW]}.
- One sub-module, wb_fifo: DEPTH-entry circular buffer with push/pop/count/full/empty and an entry-valid vector exported for the pend_mask decode.
- Arbitration and the output register stay in reg_writeback.

Test Plan:
1. Reset: hold rst_n=0 mid-cycle -> ctl_regWrite=0, instrToWrite=0, reg_writeData=0, pend_mask=0, alu_ready=0 immediately. Release -> alu_ready=1.
2. Lone ALU: alu_valid, dest=5, data=32'hDEADBEEF -> next cycle ctl_regWrite=1, instrToWrite=5, reg_writeData=32'hDEADBEEF for one cycle; pend_mask stays 0.
3. Conflict: same cycle ld dest=3 data=32'h11 and alu dest=7 data=32'h22 -> cycle+1 write r3=32'h11 with pend_mask[7]=1; cycle+2 write r7=32'h22; then pend_mask=0, busy=0.
4. Fill/drain: ld_valid held 6 cycles with alu_valid each cycle, dests 1..6 -> alu_ready low after 4 accepts. Loads written for 6 cycles, then r1,r2,r3,r4 written in order. alu_ready returns high when count<4; dests 5,6 follow.
5. Zero register: alu dest=0, data=32'hFFFF -> handshake completes, ctl_regWrite stays 0, pend_mask=0; same for ld_dest=0.
6. Reset mid-drain: 3 entries queued (pend_mask bits 8,9,10), pulse rst_n low -> all outputs 0. After release, no write to r8–r10 ever occurs.
